// File: rtl/md_unit_ctrl_if.sv
// Operand/result bundle between the E-stage and the multiply/divide unit.
// master drives the MD op and operands; slave is the MD unit itself.
interface md_unit_ctrl_if;
  logic [3:0]  md_op;
  logic [31:0] reg_rs;
  logic [31:0] reg_rt;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_res;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, reg_rs, reg_rt,
    input  start, busy, md_stall, md_res, hi, lo
  );

  modport slave (
    input  md_op, reg_rs, reg_rt,
    output start, busy, md_stall, md_res, hi, lo
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed when the op is
// accepted, held in pending registers, and committed to HI/LO once the fixed latency expires.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_unit_ctrl_if.slave md
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_commit_q, pend_commit_d;

  logic        busy;
  logic        start;
  logic        is_mult;
  logic        is_div;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [31:0] uquot, urem;
  logic [31:0] quot, rem;

  assign busy    = (state_q == StBusy);
  assign is_mult = (md.md_op == OpMult) || (md.md_op == OpMultu);
  assign is_div  = (md.md_op == OpDiv) || (md.md_op == OpDivu);
  assign start   = (is_mult || is_div) && !busy;

  // Sign-extending both operands to 64 bits makes the low 64 product bits the signed product.
  always_comb begin
    if (md.md_op == OpMult) begin
      prod = {{32{md.reg_rs[31]}}, md.reg_rs} * {{32{md.reg_rt[31]}}, md.reg_rt};
    end else begin
      prod = {32'd0, md.reg_rs} * {32'd0, md.reg_rt};
    end
  end

  // Signed division on magnitudes: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    a_neg = (md.md_op == OpDiv) && md.reg_rs[31];
    b_neg = (md.md_op == OpDiv) && md.reg_rt[31];
    abs_a = a_neg ? (32'd0 - md.reg_rs) : md.reg_rs;
    abs_b = b_neg ? (32'd0 - md.reg_rt) : md.reg_rt;
    uquot = 32'd0;
    urem  = 32'd0;
    if (abs_b != 32'd0) begin
      uquot = abs_a / abs_b;
      urem  = abs_a % abs_b;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    rem  = a_neg ? (32'd0 - urem) : urem;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    pend_hi_d     = pend_hi_q;
    pend_lo_d     = pend_lo_q;
    pend_commit_d = pend_commit_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          if (is_mult) begin
            cnt_d         = MultLoad;
            pend_hi_d     = prod[63:32];
            pend_lo_d     = prod[31:0];
            pend_commit_d = 1'b1;
          end else begin
            cnt_d         = DivLoad;
            pend_hi_d     = rem;
            pend_lo_d     = quot;
            pend_commit_d = (md.reg_rt != 32'd0);
          end
        end else if (md.md_op == OpMthi) begin
          hi_d = md.reg_rs;
        end else if (md.md_op == OpMtlo) begin
          lo_d = md.reg_rs;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StIdle;
          // A zero divisor runs the full latency but leaves HI/LO untouched.
          if (pend_commit_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      pend_hi_q     <= 32'd0;
      pend_lo_q     <= 32'd0;
      pend_commit_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      pend_hi_q     <= pend_hi_d;
      pend_lo_q     <= pend_lo_d;
      pend_commit_q <= pend_commit_d;
    end
  end

  always_comb begin
    md.md_res = 32'd0;
    if (md.md_op == OpMfhi) begin
      md.md_res = hi_q;
    end else if (md.md_op == OpMflo) begin
      md.md_res = lo_q;
    end
  end

  assign md.start    = start;
  assign md.busy     = busy;
  assign md.md_stall = start | busy;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: each issued mult/div pushes its expected HI/LO and latency,
// and a negedge monitor pops and compares whenever busy falls.
module tb_md_unit_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk;
  logic reset;

  md_unit_ctrl_if md ();

  md_unit_ctrl #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = 32'd0;
  logic [31:0] exp_lo   = 32'd0;
  logic        busy_prev = 1'b0;
  int          busy_len  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: busy falling marks a completed op; compare committed HI/LO and measured latency.
  always @(negedge clk) begin
    if (!reset) begin
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (md.busy === 1'b1) busy_len++;
      if (busy_prev && md.busy === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: completion with empty scoreboard");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check32("sb_hi", md.hi, e.hi);
          check32("sb_lo", md.lo, e.lo);
          check32("sb_latency", 32'(busy_len), 32'(e.len));
        end
        busy_len = 0;
      end
      busy_prev = (md.busy === 1'b1);
    end
  end

  function automatic void expect_op(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.len = n;
    sb_q.push_back(e);
    exp_hi = h;
    exp_lo = l;
  endfunction

  // Called at posedge+1; holds the op for one sampling edge and returns at posedge+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic exp_start);
    md.md_op  = op;
    md.reg_rs = rs;
    md.reg_rt = rt;
    #1;
    check32("start", 32'(md.start), 32'(exp_start));
    if (exp_start) check32("md_stall_on_start", 32'(md.md_stall), 32'd1);
    @(posedge clk);
    #1;
    md.md_op = 4'd0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (md.busy === 1'b1 && i < 50) begin
      @(posedge clk);
      #1;
      i++;
    end
    check32("idle_timeout", 32'(md.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_lo;
    reset     = 1'b0;
    md.md_op  = 4'd0;
    md.reg_rs = 32'd0;
    md.reg_rt = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_busy", 32'(md.busy), 32'd0);
    check32("rst_hi", md.hi, 32'd0);
    check32("rst_lo", md.lo, 32'd0);
    check32("rst_stall", 32'(md.md_stall), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // mult -3 * 5
    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFF1, MultN);
    issue(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    check32("busy_after_start", 32'(md.busy), 32'd1);
    wait_idle();

    // multu 0xFFFFFFFF * 2
    expect_op(32'h0000_0001, 32'hFFFF_FFFE, MultN);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle();

    // div -7 / 2, then divu back-to-back in the cycle right after busy falls
    expect_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, DivN);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle();
    expect_op(32'h0000_0001, 32'h7FFF_FFFC, DivN);
    issue(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle();
    md.md_op = 4'd5;
    #1;
    check32("mfhi", md.md_res, 32'h0000_0001);
    md.md_op = 4'd12;
    #1;
    check32("md_res_none", md.md_res, 32'd0);
    @(posedge clk);
    #1;
    check32("op12_no_busy", 32'(md.busy), 32'd0);
    check32("op12_hi_kept", md.hi, 32'h0000_0001);
    md.md_op = 4'd0;

    // overflow case
    expect_op(32'h0000_0000, 32'h8000_0000, DivN);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // mthi then divide by zero: full latency, no commit
    issue(4'd7, 32'h0000_1234, 32'd0, 1'b0);
    check32("mthi", md.hi, 32'h0000_1234);
    expect_op(32'h0000_1234, exp_lo, DivN);
    issue(4'd3, 32'd9, 32'd0, 1'b1);
    wait_idle();

    // mtlo ignored while busy; mflo returns the old LO
    old_lo = exp_lo;
    expect_op(32'd0, 32'd42, MultN);
    issue(4'd1, 32'd7, 32'd6, 1'b1);
    issue(4'd8, 32'h0000_00AA, 32'd0, 1'b0);
    check32("mtlo_busy_ignored", md.lo, old_lo);
    md.md_op = 4'd6;
    #1;
    check32("mflo_busy_old", md.md_res, old_lo);
    check32("stall_busy", 32'(md.md_stall), 32'd1);
    md.md_op = 4'd0;
    wait_idle();

    // async reset during busy cycle 3 of a div
    expect_op(32'd2, 32'd14, DivN);
    issue(4'd3, 32'd100, 32'd7, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check32("arst_busy", 32'(md.busy), 32'd0);
    check32("arst_hi", md.hi, 32'd0);
    check32("arst_lo", md.lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    expect_op(32'd0, 32'd12, MultN);
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    wait_idle();
    md.md_op = 4'd6;
    #1;
    check32("mflo_after", md.md_res, 32'd12);
    md.md_op = 4'd0;

    @(negedge clk);
    #1;
    check32("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
